// File: rtl/gcd_controller_if.sv
// Handshake and datapath-control bundle between the GCD controller, its requester and the GCD datapath.
// master = requester plus datapath side; slave = the controller.
interface gcd_controller_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             a_gt_b;
  logic             a_lt_b;
  logic             a_eq_b;
  logic             a_sel;
  logic             a_ld;
  logic             b_sel;
  logic             b_ld;
  logic             op_enb;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] iter;

  modport master (
    output start, abort, in1, in2, a_gt_b, a_lt_b, a_eq_b,
    input  a_sel, a_ld, b_sel, b_ld, op_enb, busy, done, err, iter
  );

  modport slave (
    input  start, abort, in1, in2, a_gt_b, a_lt_b, a_eq_b,
    output a_sel, a_ld, b_sel, b_ld, op_enb, busy, done, err, iter
  );
endinterface

// File: rtl/gcd_controller.sv
// Control FSM for the subtractive GCD datapath: sequences load/subtract/store strobes,
// checks operands and comparator flags, and bounds the number of subtract steps.
module gcd_controller #(
  parameter int WIDTH    = 8,
  parameter int MAX_ITER = 255,
  parameter int CNT_W    = 8
) (
  input  logic            clk,
  input  logic            rst,
  gcd_controller_if.slave bus
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_CMP   = 3'd2;
  localparam logic [2:0] S_SUBA  = 3'd3;
  localparam logic [2:0] S_SUBB  = 3'd4;
  localparam logic [2:0] S_STORE = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
  localparam logic [2:0] S_ERR   = 3'd7;

  logic [2:0]       r_state, w_next;
  logic [CNT_W-1:0] r_iter;
  logic [WIDTH-1:0] w_in1, w_in2;
  logic             w_zero, w_one_flag, w_run, w_abort;
  logic             w_a_sel, w_a_ld, w_b_sel, w_b_ld, w_op_enb, w_busy, w_done, w_err;

  assign w_in1  = bus.in1;
  assign w_in2  = bus.in2;
  assign w_zero = (w_in1 == '0) || (w_in2 == '0);
  // XOR is set for one or three flags; the AND term rejects three.
  assign w_one_flag = (bus.a_gt_b ^ bus.a_lt_b ^ bus.a_eq_b) &
                      ~(bus.a_gt_b & bus.a_lt_b & bus.a_eq_b);
  assign w_run   = (r_state == S_LOAD) || (r_state == S_CMP) || (r_state == S_SUBA) ||
                   (r_state == S_SUBB) || (r_state == S_STORE);
  assign w_abort = bus.abort && w_run;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = w_zero ? S_ERR : S_LOAD;
      S_LOAD:  w_next = S_CMP;
      S_CMP: begin
        if (!w_one_flag)                    w_next = S_ERR;
        else if (bus.a_eq_b)                w_next = S_STORE;
        else if (r_iter == CNT_W'(MAX_ITER)) w_next = S_ERR;
        else if (bus.a_gt_b)                w_next = S_SUBA;
        else                                w_next = S_SUBB;
      end
      S_SUBA, S_SUBB: w_next = S_CMP;
      S_STORE: w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
    if (w_abort) w_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_iter  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && bus.start && !w_zero)
        r_iter <= '0;
      else if ((r_state == S_SUBA || r_state == S_SUBB) && !w_abort && r_iter != '1)
        r_iter <= r_iter + 1'b1;
    end
  end

  // Moore decode: strobes depend on the registered state only, so reset drops them at once.
  always_comb begin
    w_a_sel  = 1'b0;
    w_a_ld   = 1'b0;
    w_b_sel  = 1'b0;
    w_b_ld   = 1'b0;
    w_op_enb = 1'b0;
    w_busy   = 1'b0;
    w_done   = 1'b0;
    w_err    = 1'b0;
    case (r_state)
      S_LOAD: begin
        w_a_sel = 1'b1; w_a_ld = 1'b1; w_b_sel = 1'b1; w_b_ld = 1'b1; w_busy = 1'b1;
      end
      S_CMP:   w_busy = 1'b1;
      S_SUBA:  begin w_a_ld = 1'b1; w_busy = 1'b1; end
      S_SUBB:  begin w_b_ld = 1'b1; w_busy = 1'b1; end
      S_STORE: begin w_op_enb = 1'b1; w_busy = 1'b1; end
      S_DONE:  w_done = 1'b1;
      S_ERR:   begin w_done = 1'b1; w_err = 1'b1; end
      default: ;
    endcase
  end

  assign bus.a_sel  = w_a_sel;
  assign bus.a_ld   = w_a_ld;
  assign bus.b_sel  = w_b_sel;
  assign bus.b_ld   = w_b_ld;
  assign bus.op_enb = w_op_enb;
  assign bus.busy   = w_busy;
  assign bus.done   = w_done;
  assign bus.err    = w_err;
  assign bus.iter   = r_iter;
endmodule

// File: tb/tb_gcd_controller.sv
// Directed bench: drives the controller together with a small behavioural GCD datapath.
module tb_gcd_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gcd_controller_if #(.WIDTH(8), .CNT_W(8)) bus1 ();
  gcd_controller_if #(.WIDTH(8), .CNT_W(8)) bus2 ();

  gcd_controller #(.WIDTH(8), .MAX_ITER(255), .CNT_W(8)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  gcd_controller #(.WIDTH(8), .MAX_ITER(4),   .CNT_W(8)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  // Datapath models; flags on bus1 can be overridden to inject inconsistent comparator results.
  logic [7:0] ra1 = 8'd0, rb1 = 8'd0, ro1 = 8'd0;
  logic [7:0] ra2 = 8'd0, rb2 = 8'd0, ro2 = 8'd0;
  logic       frc = 1'b0;
  logic [2:0] frc_val = 3'b000;

  assign {bus1.a_gt_b, bus1.a_lt_b, bus1.a_eq_b} = frc ? frc_val : {ra1 > rb1, ra1 < rb1, ra1 == rb1};
  assign {bus2.a_gt_b, bus2.a_lt_b, bus2.a_eq_b} = {ra2 > rb2, ra2 < rb2, ra2 == rb2};

  always @(posedge clk) begin
    if (bus1.a_ld)   ra1 <= bus1.a_sel ? bus1.in1 : ra1 - rb1;
    if (bus1.b_ld)   rb1 <= bus1.b_sel ? bus1.in2 : rb1 - ra1;
    if (bus1.op_enb) ro1 <= ra1;
    if (bus2.a_ld)   ra2 <= bus2.a_sel ? bus2.in1 : ra2 - rb2;
    if (bus2.b_ld)   rb2 <= bus2.b_sel ? bus2.in2 : rb2 - ra2;
    if (bus2.op_enb) ro2 <= ra2;
  end

  int n_ld = 0, n_op = 0, n_done = 0, n_op2 = 0;
  always @(negedge clk) begin
    if (bus1.a_ld || bus1.b_ld) n_ld++;
    if (bus1.op_enb)            n_op++;
    if (bus1.done)              n_done++;
    if (bus2.op_enb)            n_op2++;
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic clr_cnt();
    n_ld = 0; n_op = 0; n_done = 0; n_op2 = 0;
  endtask

  // Called at a negedge; returns at the negedge just after the sampling edge of start.
  task automatic pulse1(input logic [7:0] a, input logic [7:0] b);
    bus1.in1 = a; bus1.in2 = b; bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
  endtask

  // lat counts sampled edges, 1 = the edge that took start.
  task automatic wait_done1(output int lat);
    lat = 1;
    while (!bus1.done && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
  endtask

  function automatic logic [31:0] outs1();
    return {bus1.a_sel, bus1.a_ld, bus1.b_sel, bus1.b_ld, bus1.op_enb,
            bus1.busy, bus1.done, bus1.err, bus1.iter};
  endfunction

  function automatic logic [31:0] outs2();
    return {bus2.a_sel, bus2.a_ld, bus2.b_sel, bus2.b_ld, bus2.op_enb,
            bus2.busy, bus2.done, bus2.err, bus2.iter};
  endfunction

  initial begin
    int lat;
    bus1.start = 0; bus1.abort = 0; bus1.in1 = 0; bus1.in2 = 0;
    bus2.start = 0; bus2.abort = 0; bus2.in1 = 0; bus2.in2 = 0;
    #1;
    chk("reset_outs1", outs1(), 0);
    chk("reset_outs2", outs2(), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1: 12,8 -> 4 after two steps
    clr_cnt();
    pulse1(8'd12, 8'd8);
    chk("t1_busy_load", bus1.busy, 1);
    wait_done1(lat);
    chk("t1_latency", lat, 8);
    chk("t1_out", ro1, 4);
    chk("t1_iter", bus1.iter, 2);
    chk("t1_err", bus1.err, 0);
    chk("t1_busy_done", bus1.busy, 0);
    @(negedge clk);
    chk("t1_done_1cyc", bus1.done, 0);

    // 2: 255,1 -> 1 after 254 steps
    pulse1(8'd255, 8'd1);
    wait_done1(lat);
    chk("t2_latency", lat, 512);
    chk("t2_out", ro1, 1);
    chk("t2_iter", bus1.iter, 254);
    chk("t2_err", bus1.err, 0);
    @(negedge clk);

    // 3: zero operand -> immediate error, nothing loaded
    clr_cnt();
    pulse1(8'd0, 8'd7);
    wait_done1(lat);
    chk("t3_latency", lat, 1);
    chk("t3_err", bus1.err, 1);
    @(negedge clk);
    chk("t3_done_1cyc", bus1.done, 0);
    chk("t3_err_1cyc", bus1.err, 0);
    chk("t3_no_ld", n_ld, 0);
    chk("t3_no_op", n_op, 0);
    chk("t3_out_kept", ro1, 1);

    // 4: MAX_ITER=4 overrun on the second controller
    clr_cnt();
    bus2.in1 = 8'd200; bus2.in2 = 8'd3; bus2.start = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
    lat = 1;
    while (!bus2.done && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    chk("t4_latency", lat, 11);
    chk("t4_err", bus2.err, 1);
    chk("t4_iter", bus2.iter, 4);
    chk("t4_no_op", n_op2, 0);
    chk("t4_out_kept", ro2, 0);
    @(negedge clk);

    // 5: abort during first SUBA, then restart with start and abort both high
    clr_cnt();
    pulse1(8'd9, 8'd6);
    @(negedge clk); @(negedge clk);
    chk("t5_in_suba", bus1.a_ld && !bus1.a_sel, 1);
    bus1.abort = 1'b1;
    @(negedge clk);
    bus1.abort = 1'b0;
    chk("t5_abort_busy", bus1.busy, 0);
    chk("t5_abort_iter", bus1.iter, 0);
    repeat (3) @(negedge clk);
    chk("t5_abort_nodone", n_done, 0);
    chk("t5_abort_noop", n_op, 0);
    bus1.abort = 1'b1;
    pulse1(8'd9, 8'd6);
    bus1.abort = 1'b0;
    chk("t5_start_over_abort", bus1.busy, 1);
    wait_done1(lat);
    chk("t5_latency", lat, 8);
    chk("t5_out", ro1, 3);
    chk("t5_err", bus1.err, 0);
    @(negedge clk);

    // 6a: inconsistent flags in CMP
    frc = 1'b1; frc_val = 3'b101;
    pulse1(8'd5, 8'd5);
    wait_done1(lat);
    chk("t6_multi_lat", lat, 3);
    chk("t6_multi_err", bus1.err, 1);
    @(negedge clk);
    frc_val = 3'b000;
    pulse1(8'd5, 8'd5);
    wait_done1(lat);
    chk("t6_none_lat", lat, 3);
    chk("t6_none_err", bus1.err, 1);
    frc = 1'b0;
    @(negedge clk);

    // 6b: reset while in SUBB
    pulse1(8'd4, 8'd12);
    @(negedge clk); @(negedge clk);
    chk("t6_in_subb", bus1.b_ld && !bus1.b_sel, 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_outs", outs1(), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 6c: start while busy is ignored
    clr_cnt();
    pulse1(8'd12, 8'd8);
    @(negedge clk);
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    repeat (15) @(negedge clk);
    chk("t6_single_done", n_done, 1);
    chk("t6_busy_out", ro1, 4);
    chk("t6_busy_iter", bus1.iter, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/gcd_controller.md
Name: gcd_controller

Overview:
- Control FSM for the GCD datapath. It is the stage that drives the datapath's mux-select, load and output-enable strobes and consumes its comparator flags.
- Provides a start/busy/done/err handshake to the upstream requester.
- Detects zero operands, an iteration-limit overrun, and inconsistent comparator flags.
- Pure control: it holds no operand data.

Parameters:
- WIDTH, 8: operand width of in1/in2, used only for the zero check.
- MAX_ITER, 255: maximum number of subtract steps before an error abort.
- CNT_W, 8: iteration counter width; must satisfy 2^CNT_W > MAX_ITER.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a GCD run; sampled only in IDLE
- abort  input  1  synchronous cancel; returns FSM to IDLE
- in1  input  WIDTH  operand A (same bus that feeds the datapath)
- in2  input  WIDTH  operand B
- a_gt_b  input  1  datapath comparator: A > B
- a_lt_b  input  1  datapath comparator: A < B
- a_eq_b  input  1  datapath comparator: A == B
- a_sel  output  1  1 = A register loads in1; 0 = A register loads A-B
- a_ld  output  1  A register load enable
- b_sel  output  1  1 = B register loads in2; 0 = B register loads B-A
- b_ld  output  1  B register load enable
- op_enb  output  1  output register captures A
- busy  output  1  run in progress
- done  output  1  one-cycle completion pulse
- err  output  1  one-cycle error pulse; coincident with done
- iter  output  CNT_W  subtract steps taken in current/last run

Behaviour:
- Reset (async, rst=1): state=IDLE; every output, including iter, is 0.
- All strobe outputs are Moore outputs, decoded from the registered state only.
- Strobe outputs are 0 in any state not listed below.
- IDLE: busy=0.
  - start=1 with in1==0 or in2==0 -> ERR.
  - start=1 otherwise -> LOAD; iter cleared to 0.
- LOAD: a_sel=b_sel=1, a_ld=b_ld=1, busy=1 -> CMP.
  - in1/in2 must be held stable from the start cycle through LOAD.
- CMP: busy=1. Flags reflect the registers loaded on the previous edge.
  - Exactly one flag set is required. Zero or multiple flags set -> ERR.
  - a_eq_b -> STORE.
  - a_gt_b or a_lt_b with iter==MAX_ITER -> ERR.
  - a_gt_b -> SUBA.
  - a_lt_b -> SUBB.
- SUBA: a_sel=0, a_ld=1, busy=1; iter+=1 -> CMP.
- SUBB: b_sel=0, b_ld=1, busy=1; iter+=1 -> CMP.
- STORE: op_enb=1, busy=1 -> DONE.
- DONE: done=1, busy=0 -> IDLE. The datapath output holds the GCD from this cycle on.
- ERR: done=1, err=1, busy=0 -> IDLE. op_enb is never asserted, so the previous result is retained.
- Latency: with start sampled at edge k and N subtract steps, done is high in cycle k+2N+4.
- Throughput: a new start is accepted in the cycle after DONE/ERR (IDLE).
- start while not in IDLE is ignored; there is no queueing.
- abort:
  - Takes priority over all transitions in LOAD/CMP/SUBA/SUBB/STORE.
  - Next state is IDLE, with no done/err pulse and no op_enb.
  - iter is frozen at its current value.
  - abort in IDLE/DONE/ERR has no effect.
- start and abort both high in IDLE: abort is ignored, start is honoured.
- iter saturates. It cannot wrap because of the MAX_ITER check in CMP.
- rst mid-run: immediate return to IDLE; all strobes drop asynchronously.

Test Plan:
1. in1=12, in2=8, start pulse.
   - Required states: LOAD, CMP, SUBA, CMP, SUBB, CMP, STORE, DONE.
   - Required response: done at k+8, out=4, iter=2, err=0.
2. in1=255, in2=1, start pulse.
   - Required response: 254 SUBA steps, done at k+512, out=1, iter=254, err=0.
3. in1=0, in2=7, start pulse.
   - Required response: ERR the next cycle; done=err=1 for one cycle; no a_ld/b_ld/op_enb ever asserted; out unchanged.
4. MAX_ITER=4, in1=200, in2=3.
   - Required response: after 4 SUBA steps, CMP sees a_gt_b -> err=done=1; op_enb never asserted.
5. in1=9, in2=6; abort asserted during the first SUBA; start re-pulsed in a later cycle.
   - Abort: IDLE the next cycle; no done; busy=0.
   - Re-pulsed start: done with out=3.
6. Robustness checks:
   - Force a_gt_b=a_eq_b=1 in CMP -> err pulse.
   - Assert rst mid-SUBB -> all outputs 0 immediately.
   - Pulse start while busy -> ignored, single done.
